// File: rtl/fifo_read_ctrl.sv
// Read-side FIFO controller: issues memory reads while the memory holds words
// and the 2-entry output buffer has room, then streams the words out on valid/ready.
module fifo_read_ctrl #(
    parameter int N    = 8,
    parameter int DEEP = 8
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic [DEEP:0]   wr_ptr,
    output logic            mem_r_en,
    output logic [DEEP-1:0] mem_address_r,
    input  logic [N-1:0]    mem_data,
    output logic [DEEP:0]   rd_ptr,
    output logic [N-1:0]    data_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            empty,
    output logic [DEEP+1:0] level
);

    logic [DEEP:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic [N-1:0]  head_q, head_d;
    logic [N-1:0]  tail_q, tail_d;

    logic          mem_empty;
    logic          pop;
    logic [DEEP:0] mem_entries;

    assign mem_empty = (wr_ptr == rd_ptr_q);

    // Issue depends only on registered occupancy, keeping ready_i off the memory path.
    assign mem_r_en      = rst_n && !mem_empty && (count_q != 2'd2);
    assign mem_address_r = rd_ptr_q[DEEP-1:0];
    assign pop           = valid_o && ready_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        tail_d   = tail_q;

        if (mem_r_en) begin
            rd_ptr_d = rd_ptr_q + (DEEP+1)'(1);
        end

        // Capture with pop is only possible at count 1, so the new word becomes the head.
        case ({mem_r_en, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = mem_data;
                end else begin
                    tail_d = mem_data;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                head_d = mem_data;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
        end
    end

    assign mem_entries = wr_ptr - rd_ptr_q;

    assign rd_ptr  = rd_ptr_q;
    assign data_o  = head_q;
    assign valid_o = (count_q != 2'd0);
    assign empty   = mem_empty && (count_q == 2'd0);
    assign level   = {1'b0, mem_entries} + {{DEEP{1'b0}}, count_q};

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl (DEEP=3): a write-side/memory model around the DUT,
// a queue-based reference model, directed vectors, corner sequences and random traffic.
module tb_fifo_read_ctrl;

    localparam int N    = 8;
    localparam int DEEP = 3;
    localparam int SLOTS = 1 << DEEP;

    logic            clk_in;
    logic            rst_n;
    logic [DEEP:0]   wr_ptr;
    logic            mem_r_en;
    logic [DEEP-1:0] mem_address_r;
    logic [N-1:0]    mem_data;
    logic [DEEP:0]   rd_ptr;
    logic [N-1:0]    data_o;
    logic            valid_o;
    logic            ready_i;
    logic            empty;
    logic [DEEP+1:0] level;

    fifo_read_ctrl #(.N(N), .DEEP(DEEP)) dut (
        .clk_in        (clk_in),
        .rst_n         (rst_n),
        .wr_ptr        (wr_ptr),
        .mem_r_en      (mem_r_en),
        .mem_address_r (mem_address_r),
        .mem_data      (mem_data),
        .rd_ptr        (rd_ptr),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .empty         (empty),
        .level         (level)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    logic [N-1:0] mem [SLOTS];

    // Memory samples the read address on the falling edge of the issue cycle.
    always @(negedge clk_in) begin
        if (mem_r_en === 1'b1) begin
            mem_data = mem[mem_address_r];
        end
    end

    int tests_run  = 0;
    int fail_count = 0;

    logic [N-1:0] mem_q[$];
    logic [N-1:0] buf_q[$];
    logic [N-1:0] delivered[$];
    int           issued = 0;
    bit           armed = 0;
    bit           reset_prev = 0;

    always @(negedge clk_in) begin
        if (armed && rst_n === 1'b1) begin
            assert (4'(wr_ptr - rd_ptr) <= 4'(SLOTS))
            else $error("[TB] illegal memory occupancy wr_ptr=%0d rd_ptr=%0d", wr_ptr, rd_ptr);
        end
    end

    typedef struct {
        logic       rst;
        logic       push;
        logic [7:0] wd;
        logic       rdy;
        logic       chk;
        logic       en;
        logic       valid;
        logic [7:0] data;
        logic       cd;
        logic [3:0] rd;
        logic [4:0] lvl;
        logic       emp;
    } vec_t;

    function automatic vec_t mk(int r, int push, int wd, int rdy, int chk, int en,
                                int v, int d, int cd, int rd, int lvl, int e);
        vec_t m;
        m.rst = r[0];  m.push = push[0]; m.wd = wd[7:0];  m.rdy = rdy[0];
        m.chk = chk[0]; m.en = en[0];    m.valid = v[0];  m.data = d[7:0];
        m.cd = cd[0];  m.rd = rd[3:0];   m.lvl = lvl[4:0]; m.emp = e[0];
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge; the write side pushes only when not full.
    task automatic applyStimulus(input logic r, input logic push, input logic [7:0] wd, input logic rdy);
        rst_n   = r;
        ready_i = rdy;
        if (!r) begin
            wr_ptr = '0;
            mem_q.delete();
        end else if (push && mem_q.size() < SLOTS) begin
            mem[wr_ptr[DEEP-1:0]] = wd;
            wr_ptr = wr_ptr + 4'd1;
            mem_q.push_back(wd);
        end
        #5;
    endtask

    task automatic checkOutput();
        int total;
        if (!armed) return;
        if (!rst_n) begin
            chk("mem_r_en_in_reset", 32'(mem_r_en), 32'd0);
            return;
        end
        total = mem_q.size() + buf_q.size();
        chk("mem_r_en", 32'(mem_r_en), 32'(mem_q.size() != 0 && buf_q.size() < 2));
        chk("mem_address_r", 32'(mem_address_r), 32'(issued % SLOTS));
        chk("rd_ptr", 32'(rd_ptr), 32'(issued % (2 * SLOTS)));
        chk("valid_o", 32'(valid_o), 32'(buf_q.size() != 0));
        if (buf_q.size() != 0) chk("data_o", 32'(data_o), 32'(buf_q[0]));
        else if (reset_prev) chk("data_o_after_reset", 32'(data_o), 32'd0);
        chk("level", 32'(level), 32'(total));
        chk("empty", 32'(empty), 32'(total == 0));
    endtask

    task automatic advance();
        bit do_pop;
        bit do_issue;
        if (rst_n && valid_o && ready_i) delivered.push_back(data_o);
        @(posedge clk_in);
        if (!rst_n) begin
            buf_q.delete();
            issued     = 0;
            armed      = 1;
            reset_prev = 1;
        end else begin
            reset_prev = 0;
            do_pop   = (buf_q.size() != 0) && ready_i;
            do_issue = (mem_q.size() != 0) && (buf_q.size() < 2);
            if (do_pop) void'(buf_q.pop_front());
            if (do_issue) begin
                buf_q.push_back(mem_q.pop_front());
                issued++;
            end
        end
        #1;
    endtask

    task automatic cycle(input logic r, input logic push, input logic [7:0] wd, input logic rdy);
        applyStimulus(r, push, wd, rdy);
        checkOutput();
        advance();
    endtask

    vec_t vec[10];

    initial begin
        rst_n    = 1'b0;
        wr_ptr   = '0;
        ready_i  = 1'b0;
        mem_data = '0;
        for (int i = 0; i < SLOTS; i++) mem[i] = '0;

        vec[0] = mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1);
        vec[1] = mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 1, 0, 0, 1);
        vec[2] = mk(1, 1, 8'hA5, 0, 1, 1, 0, 8'h00, 1, 0, 1, 0);
        vec[3] = mk(1, 0, 8'h00, 0, 1, 0, 1, 8'hA5, 1, 1, 1, 0);
        vec[4] = mk(1, 0, 8'h00, 0, 1, 0, 1, 8'hA5, 1, 1, 1, 0);
        vec[5] = mk(1, 0, 8'h00, 1, 1, 0, 1, 8'hA5, 1, 1, 1, 0);
        vec[6] = mk(1, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1, 0, 1);
        vec[7] = mk(1, 1, 8'h3C, 1, 1, 1, 0, 8'h00, 0, 1, 1, 0);
        vec[8] = mk(1, 0, 8'h00, 1, 1, 0, 1, 8'h3C, 1, 2, 1, 0);
        vec[9] = mk(1, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 2, 0, 1);

        @(posedge clk_in);
        #1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vec[i].rst, vec[i].push, vec[i].wd, vec[i].rdy);
            if (vec[i].chk) begin
                chk("vec_mem_r_en", 32'(mem_r_en), 32'(vec[i].en));
                chk("vec_valid_o", 32'(valid_o), 32'(vec[i].valid));
                if (vec[i].cd) chk("vec_data_o", 32'(data_o), 32'(vec[i].data));
                chk("vec_rd_ptr", 32'(rd_ptr), 32'(vec[i].rd));
                chk("vec_level", 32'(level), 32'(vec[i].lvl));
                chk("vec_empty", 32'(empty), 32'(vec[i].emp));
                if (vec[i].en) chk("vec_mem_address_r", 32'(mem_address_r), 32'(vec[i].rd[DEEP-1:0]));
            end
            checkOutput();
            advance();
        end

        // Streaming: one word per cycle, ready held high, no bubbles.
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, i < 10, 8'(8'h10 + i), 1'b1);
            checkOutput();
            if (i >= 1 && i <= 10) begin
                chk("stream_valid", 32'(valid_o), 32'd1);
                chk("stream_data", 32'(data_o), 32'(8'h0F + i));
            end
            if (i == 11) begin
                chk("stream_rd_ptr", 32'(rd_ptr), 32'd10);
                chk("stream_empty", 32'(empty), 32'd1);
            end
            advance();
        end

        // Backpressure: only two issues with ready low, then ordered delivery under toggling ready.
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'(8'h50 + i), 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput();
        chk("bp_rd_ptr", 32'(rd_ptr), 32'd2);
        chk("bp_level", 32'(level), 32'd5);
        chk("bp_mem_r_en", 32'(mem_r_en), 32'd0);
        chk("bp_head", 32'(data_o), 32'h50);
        advance();
        delivered.delete();
        for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 8'h00, i % 2 == 0);
        chk("bp_count", 32'(delivered.size()), 32'd5);
        for (int k = 0; k < 5 && k < delivered.size(); k++) chk("bp_order", 32'(delivered[k]), 32'(8'h50 + k));

        // Wrap-around: 20 words through an 8-slot memory so the pointer passes 15 -> 0.
        begin
            bit           wrapped;
            logic [DEEP:0] last_rd;
            cycle(1'b0, 1'b0, 8'h00, 1'b0);
            delivered.delete();
            wrapped = 0;
            last_rd = '0;
            for (int i = 0; i < 24; i++) begin
                applyStimulus(1'b1, i < 20, 8'(8'h80 + i), 1'b1);
                if (last_rd == 4'd15 && rd_ptr == 4'd0) wrapped = 1;
                last_rd = rd_ptr;
                checkOutput();
                advance();
            end
            chk("wrap_seen", 32'(wrapped), 32'd1);
            chk("wrap_rd_ptr", 32'(rd_ptr), 32'd4);
            chk("wrap_count", 32'(delivered.size()), 32'd20);
            for (int k = 0; k < 20 && k < delivered.size(); k++) chk("wrap_order", 32'(delivered[k]), 32'(8'h80 + k));
        end

        // Reset in the middle of a burst with a full buffer and words still in memory.
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
            checkOutput();
            chk("rst_mid_mem_r_en", 32'(mem_r_en), 32'd0);
            if (i == 0) begin
                chk("rst_mid_rd_ptr", 32'(rd_ptr), 32'd0);
                chk("rst_mid_valid", 32'(valid_o), 32'd0);
                chk("rst_mid_data", 32'(data_o), 32'd0);
            end
            advance();
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 6,
                  8'($urandom), $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
